// File: rtl/mux_scan_seq.sv
// Scan sequencer around an 8:1 byte mux: drives sel_o, waits for the settle time, then streams each enabled channel's byte.
// Optional continuous-scan mode: define MUX_SCAN_CONT_EN.
module mux_scan_seq #(
    parameter int Width        = 8,
    parameter int SettleCycles = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [7:0]       mask_i,
    input  logic [Width-1:0] mux_y_i,
    output logic [2:0]       sel_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [2:0]       out_ch_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SettleCycles - 1);

    // Lowest set bit of m at index >= lo; 8 means none (bit 3 set).
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (4'(k) >= lo)) begin
                r = 4'(k);
            end
        end
        return r;
    endfunction

    state_t           state_r;
    logic [7:0]       mask_r;
    logic [3:0]       cnt_r;
    logic [2:0]       sel_r;
    logic             valid_r;
    logic [Width-1:0] data_r;
    logic [2:0]       ch_r;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       first_s;
    logic [3:0]       next_s;

    // Channel search: first channel of a new mask, next channel above the current select.
    always_comb begin
        first_s = find_from(mask_i, 4'd0);
        next_s  = find_from(mask_r, {1'b0, sel_r} + 4'd1);
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            mask_r  <= 8'd0;
            cnt_r   <= 4'd0;
            sel_r   <= 3'd0;
            valid_r <= 1'b0;
            data_r  <= '0;
            ch_r    <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i && (mask_i != 8'd0)) begin
                        mask_r  <= mask_i;
                        sel_r   <= first_s[2:0];
                        cnt_r   <= SETTLE_LOAD;
                        busy_r  <= 1'b1;
                        state_r <= SETTLE;
                    end else if (start_i) begin
                        done_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        data_r  <= mux_y_i;
                        ch_r    <= sel_r;
                        valid_r <= 1'b1;
                        state_r <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready_i) begin
                        valid_r <= 1'b0;
                        if (!next_s[3]) begin
                            sel_r   <= next_s[2:0];
                            cnt_r   <= SETTLE_LOAD;
                            state_r <= SETTLE;
                        end else begin
                            done_r <= 1'b1;
`ifdef MUX_SCAN_CONT_EN
                            // Back-to-back scan: restart straight from the last handshake.
                            if (start_i && (mask_i != 8'd0)) begin
                                mask_r  <= mask_i;
                                sel_r   <= first_s[2:0];
                                cnt_r   <= SETTLE_LOAD;
                                state_r <= SETTLE;
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end
`else
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
`endif
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o       = sel_r;
    assign out_valid_o = valid_r;
    assign out_data_o  = data_r;
    assign out_ch_o    = ch_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: scoreboard of expected (channel, byte) beats popped on each handshake.
module tb_mux_scan_seq;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mask = 8'd0;
    logic [7:0] mux_in [8];
    logic [7:0] mux_y;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [2:0] out_ch;
    logic       busy;
    logic       done;

    logic       start3 = 1'b0;
    logic [7:0] mask3 = 8'd0;
    logic [7:0] y3 = 8'h00;
    logic [2:0] sel3;
    logic       valid3;
    logic       ready3 = 1'b1;
    logic [7:0] data3;
    logic [2:0] ch3;
    logic       busy3;
    logic       done3;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    beat_t sb [$];
    int    hs_q [$];

    always #5 clk = ~clk;

    assign mux_y = mux_in[sel];

    mux_scan_seq #(.Width(8), .SettleCycles(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mask_i(mask), .mux_y_i(mux_y),
        .sel_o(sel), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_ch_o(out_ch), .busy_o(busy), .done_o(done)
    );

    mux_scan_seq #(.Width(8), .SettleCycles(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .mask_i(mask3), .mux_y_i(y3),
        .sel_o(sel3), .out_valid_o(valid3), .out_ready_i(ready3), .out_data_o(data3),
        .out_ch_o(ch3), .busy_o(busy3), .done_o(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Handshake monitor: pop expected beat and compare.
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            hs_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("extra_beat", {29'd0, out_ch}, 32'hFFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_ch", {29'd0, out_ch}, {29'd0, e.ch});
                chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
            end
        end
    end

    task automatic push_mask(input logic [7:0] m);
        for (int k = 0; k < 8; k++) begin
            if (m[k]) sb.push_back({3'(k), 8'((k + 1) * 17)});
        end
    endtask

    // Drive a one-cycle start; returns just after the start edge.
    task automatic start_scan(input logic [7:0] m);
        @(posedge clk); #1;
        start = 1'b1;
        mask = m;
        push_mask(m);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int d0;
        int n;
        int d;
        for (int k = 0; k < 8; k++) mux_in[k] = 8'((k + 1) * 17);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {15'd0, sel, out_valid, out_data, out_ch, busy, done},
            {15'd0, 3'd0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0});
        chk("reset_outs3", {15'd0, sel3, valid3, data3, ch3, busy3, done3}, 32'd0);
        rst_n = 1'b1;

        // Empty mask: done next cycle, select untouched
        @(posedge clk); #1;
        start = 1'b1;
        mask = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        chk("empty_done", {29'd0, done, busy, out_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("empty_sel", {29'd0, sel}, 32'd0);
        @(posedge clk); #1;
        chk("empty_done_low", {31'd0, done}, 32'd0);

        // Full scan, ready always high
        hs_q.delete();
        d0 = done_cnt;
        start_scan(8'hFF);
        chk("full_sel0", {29'd0, sel, busy}, {29'd0, 3'd0, 1'b1});
        wait_done(100, "full_timeout");
        chk("full_busy_at_done", {31'd0, busy}, 32'd0);
        chk("full_sb_empty", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_done_once", done_cnt - d0, 32'd1);
        chk("full_beats", hs_q.size(), 32'd8);
        for (int i = 1; i < hs_q.size(); i++) chk("full_gap", hs_q[i] - hs_q[i-1], 32'd2);
        chk("full_sel_kept", {29'd0, sel}, 32'd7);

        // Sparse mask with back-pressure on the first beat
        out_ready = 1'b0;
        start_scan(8'h81);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_beat", {20'd0, out_valid, out_ch, out_data}, {20'd0, 1'b1, 3'd0, 8'h11});
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        wait_done(50, "sparse_timeout");
        chk("sparse_sb_empty", sb.size(), 32'd0);

        // Start pulse mid-scan is ignored
        start_scan(8'h06);
        @(posedge clk); #1;
        start = 1'b1;
        mask = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, "busy_timeout");
        chk("busy_sb_empty", sb.size(), 32'd0);
        repeat (4) @(negedge clk);
        chk("busy_idle", {30'd0, busy, out_valid}, 32'd0);

        // Settle of 3: input changes after select switches, capture sees new value
        @(posedge clk); #1;
        start3 = 1'b1;
        mask3 = 8'h04;
        @(posedge clk); #1;
        start3 = 1'b0;
        chk("s3_sel", {29'd0, sel3}, 32'd2);
        chk("s3_valid_e0", {31'd0, valid3}, 32'd0);
        @(posedge clk); #1;
        y3 = 8'h33;
        chk("s3_valid_e1", {31'd0, valid3}, 32'd0);
        @(posedge clk); #1;
        chk("s3_valid_e2", {31'd0, valid3}, 32'd0);
        @(posedge clk); #1;
        chk("s3_capture", {20'd0, valid3, ch3, data3}, {20'd0, 1'b1, 3'd2, 8'h33});
        @(posedge clk); #1;
        chk("s3_done", {30'd0, done3, valid3}, {30'd0, 1'b1, 1'b0});

        // Reset while channel 2 is presented
        out_ready = 1'b0;
        start_scan(8'h04);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("rst_pre_ch", {28'd0, out_valid, out_ch}, {28'd0, 1'b1, 3'd2});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {15'd0, sel, out_valid, out_data, out_ch, busy, done}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        start_scan(8'h08);
        wait_done(50, "rst_timeout");
        chk("rst_sb_empty", sb.size(), 32'd0);

`ifdef MUX_SCAN_CONT_EN
        // Continuous scan while start held high
        @(posedge clk); #1;
        start = 1'b1;
        mask = 8'h03;
        push_mask(8'h03);
        push_mask(8'h03);
        push_mask(8'h03);
        @(posedge clk);
        d = 0;
        n = 0;
        while (d < 2 && n < 100) begin
            @(negedge clk);
            n++;
            chk("cont_busy", {31'd0, busy}, 32'd1);
            if (done) d++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, "cont_timeout");
        chk("cont_end_busy", {31'd0, busy}, 32'd0);
        chk("cont_sb_empty", sb.size(), 32'd0);
`else
        d = 0;
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Sequencer that sits directly upstream and downstream of the 8:1 byte multiplexer. It drives the mux select, waits for the mux output to settle, and captures each enabled channel's byte. It presents the bytes one at a time on a valid/ready stream to the next stage. A scan visits channels in ascending index order, restricted to a latched enable mask, and ends with a one-cycle done pulse.

## Interface
Parameters:
- Width, 8, data width of the mux inputs/output and of the output stream.
- SettleCycles, 1, cycles sel_o is held stable before capture; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
- start_i  input  1  begin scan; sampled only in IDLE.
- mask_i  input  8  channel enable mask (bit k = channel k, a=0 … h=7); latched on accepted start.
- mux_y_i  input  Width  mux output y_o.
- sel_o  output  3  mux select.
- out_valid_o  output  1  captured byte available.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  Width  captured byte.
- out_ch_o  output  3  channel index of out_data_o.
- busy_o  output  1  high whenever state ≠ IDLE.
- done_o  output  1  one-cycle pulse at end of scan.

## Operation
- States: IDLE, SETTLE, PRESENT.
- All outputs are registered. Reset value is 0 for every output and for the latched mask and settle counter. Reset state is IDLE.
- IDLE, start_i=1, mask_i≠0:
  - Latch the mask.
  - Set sel_o to the lowest set bit.
  - Load the settle counter with SettleCycles−1.
  - Go to SETTLE.
- IDLE, start_i=1, mask_i=0: pulse done_o on the next edge and stay in IDLE. No sel_o change and no data.
- SETTLE:
  - While the counter is not 0, decrement it.
  - When the counter is 0: out_data_o←mux_y_i, out_ch_o←sel_o, out_valid_o←1, go to PRESENT.
- PRESENT: hold out_valid_o, out_data_o and out_ch_o stable until an edge with out_ready_i=1. At that edge out_valid_o←0, then:
  - If a higher set mask bit remains, sel_o←next set bit, reload the counter, go to SETTLE.
  - Otherwise, done_o←1 for one cycle and go to IDLE. sel_o keeps its last value.
- start_i while busy_o=1 is ignored. mask_i changes after the start edge do not affect the scan in progress.
- Reset asserted mid-scan: immediately return all outputs to 0 and go to IDLE. Any partially presented byte is dropped.

## Timing
- Start accepted at edge E0. sel_o is valid after E0.
- Capture happens at edge E0+SettleCycles. out_valid_o is visible after that edge.
- Handshake at edge Eh, with more channels pending: the new sel_o is visible after Eh. The next out_valid_o rises after edge Eh+SettleCycles.
- out_valid_o is therefore low for at least SettleCycles cycles between bytes. Peak throughput is 1 byte per SettleCycles+1 cycles.
- The mux is combinational. mux_y_i is sampled only at the capture edge.
- done_o is high for exactly the cycle after the last handshake edge. busy_o is low in that same cycle.
- A new start_i can be accepted in the cycle where done_o=1.

## Configuration
- MUX_SCAN_CONT_EN defined: continuous scan.
  - At the last-channel handshake edge, if start_i=1, pulse done_o, re-latch mask_i and begin a new scan without passing through IDLE.
  - busy_o stays high.
  - If the re-latched mask is 0, go to IDLE.
- MUX_SCAN_CONT_EN undefined: always return to IDLE after the last channel, as described in Operation.

## Test plan
- Single scan: mux inputs a..h = 0x11..0x88, mask=0xFF, SettleCycles=1, out_ready_i=1. Required: 8 beats with (ch, data) = (0,0x11)…(7,0x88), beats 2 cycles apart, done_o pulses once after the last beat.
- Sparse mask: mask=0x81, out_ready_i held 0 for 5 cycles on the first beat. Required: (0,0x11) is held stable for all 6 cycles, then (7,0x88) follows, then done.
- Empty mask and busy restart: start_i with mask=0 gives a done_o pulse one cycle later and sel_o stays 0. A start_i pulse mid-scan has no effect.
- Settle parameter: SettleCycles=3, mask=0x04, with the input changed from 0x00 to 0x33 one cycle after sel_o switches. Required: captured data=0x33, out_valid_o rises 3 edges after the start edge.
- Reset mid-scan: assert rst_ni low during PRESENT of channel 2. Required: all outputs are 0 immediately, state is IDLE, and a subsequent start with mask=0x08 yields only (3,0x44).
- MUX_SCAN_CONT_EN: mask=0x03 with start_i held high. Required: the output repeats (0,0x11),(1,0x22) with a done_o pulse per scan and busy_o continuously high. Dropping start_i ends the scan after channel 1.
